// File: rtl/exponent_unit_pipe.sv
// -----------------------------------------------------------------------------
// exponent_unit_pipe
//
// Computes the biased result exponent for the FP multiplier/divider. It sits
// between operand unpacking and the normaliser/rounder.
//   multiply (sel=0): e = e_a + e_b - BIAS
//   divide   (sel=1): e = e_a - e_b + BIAS
// BIAS = 2^(EXP_W-1) - 1. The unit is a two-stage valid/ready pipeline that
// stalls as a whole under backpressure.
//
// Parameters:
//   EXP_W  exponent field width (>= 3)
//   OUT_W  signed result width (>= EXP_W+2, so the arithmetic cannot wrap)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand set valid
//   in_ready   unit accepts operands this cycle (combinational)
//   e_a, e_b   biased operand exponents
//   sel        0 = multiply, 1 = divide
//   out_valid  result valid
//   out_ready  downstream accepts result
//   e          signed result exponent
//   ovf        result > 2^EXP_W - 2
//   unf        result < 1
//   spec       an operand exponent is all-zeros or all-ones
//
// Build option:
//   EXP_SAT_EN  when defined, e is clamped to all-ones on ovf and to 0 on unf.
//               The flags are reported unchanged.
// -----------------------------------------------------------------------------
module exponent_unit_pipe #(
  parameter int EXP_W = 8,
  parameter int OUT_W = EXP_W + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W-1:0]        e_a,
  input  logic [EXP_W-1:0]        e_b,
  input  logic                    sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] e,
  output logic                    ovf,
  output logic                    unf,
  output logic                    spec
);

  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [OUT_W-1:0] BIAS_S   = OUT_W'(BIAS);
  localparam logic signed [OUT_W-1:0] MAX_NORM = OUT_W'((1 << EXP_W) - 2);
  localparam logic signed [OUT_W-1:0] ONE_S    = OUT_W'(1);
`ifdef EXP_SAT_EN
  localparam logic signed [OUT_W-1:0] SAT_ONES = OUT_W'((1 << EXP_W) - 1);
`endif

  // Both stages move together. The pipe advances whenever the output slot is
  // empty or is being drained this cycle.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // Stage 1: capture the operands and classify them.
  // ---------------------------------------------------------------------------
  logic             s1_valid;
  logic [EXP_W-1:0] s1_a;
  logic [EXP_W-1:0] s1_b;
  logic             s1_sel;
  logic             s1_spec;

  logic spec_pre;
  assign spec_pre = (e_a == '0) || (e_a == '1) || (e_b == '0) || (e_b == '1);

  // NOTE: state is updated with non-blocking assignments so that both stages
  // sample the values from before the edge and do not race each other.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset as well as the valid bits. This keeps
      // e and the flags at a defined 0 after reset at very little cost.
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sel   <= 1'b0;
      s1_spec  <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_a     <= e_a;
      s1_b     <= e_b;
      s1_sel   <= sel;
      s1_spec  <= spec_pre;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: signed arithmetic at OUT_W, range flags, optional clamp.
  // ---------------------------------------------------------------------------
  logic signed [OUT_W-1:0] a_x;
  logic signed [OUT_W-1:0] b_x;
  logic signed [OUT_W-1:0] e_raw;
  logic signed [OUT_W-1:0] e_nxt;
  logic                    ovf_nxt;
  logic                    unf_nxt;

  // NOTE: every output of this block is assigned on every path, so no latch
  // can be inferred.
  always_comb begin
    a_x     = $signed({{(OUT_W - EXP_W){1'b0}}, s1_a});
    b_x     = $signed({{(OUT_W - EXP_W){1'b0}}, s1_b});
    e_raw   = s1_sel ? (a_x - b_x + BIAS_S) : (a_x + b_x - BIAS_S);
    ovf_nxt = (e_raw > MAX_NORM);
    unf_nxt = (e_raw < ONE_S);
`ifdef EXP_SAT_EN
    if (ovf_nxt)      e_nxt = SAT_ONES;
    else if (unf_nxt) e_nxt = '0;
    else              e_nxt = e_raw;
`else
    e_nxt = e_raw;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      e         <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      spec      <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      e         <= e_nxt;
      ovf       <= ovf_nxt;
      unf       <= unf_nxt;
      spec      <= s1_spec;
    end
  end

endmodule

// File: tb/tb_exponent_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_exponent_unit_pipe
//
// Self-checking bench for exponent_unit_pipe with EXP_W=8 and OUT_W=10.
// It covers reset, directed table vectors, a backpressure sequence and a
// full-throughput stream that contains one bubble. Expected values honour
// EXP_SAT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_exponent_unit_pipe;

  localparam int EXP_W = 8;
  localparam int OUT_W = 10;
  localparam int BIAS  = 127;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] e_a;
  logic [EXP_W-1:0] e_b;
  logic             sel;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] e;
  logic             ovf;
  logic             unf;
  logic             spec;

  exponent_unit_pipe #(.EXP_W(EXP_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .e_a       (e_a),
    .e_b       (e_b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .e         (e),
    .ovf       (ovf),
    .unf       (unf),
    .spec      (spec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;
    logic [9:0] e;     // raw signed result, 10-bit two's complement
    logic       ovf;
    logic       unf;
    logic       spec;
  } vec_t;

  typedef struct {
    logic [9:0] e;
    logic       ovf;
    logic       unf;
    logic       spec;
  } res_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Converts a raw result into what e should show in the current build.
  function automatic logic [9:0] shown_e(input logic [9:0] raw, input logic o, input logic u);
`ifdef EXP_SAT_EN
    if (o)      return 10'd255;
    else if (u) return 10'd0;
    else        return raw;
`else
    return raw;
`endif
  endfunction

  // Reference model written with plain integer arithmetic.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
    res_t r;
    int   v;
    v      = s ? (int'(a) - int'(b) + BIAS) : (int'(a) + int'(b) - BIAS);
    r.ovf  = (v > 254);
    r.unf  = (v < 1);
    r.spec = (a == 8'd0) || (a == 8'd255) || (b == 8'd0) || (b == 8'd255);
    r.e    = shown_e(v[9:0], r.ovf, r.unf);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Streaming harness with a scoreboard. It is used for the backpressure and
  // throughput sequences.
  // ---------------------------------------------------------------------------
  logic [7:0] op_a   [16];
  logic [7:0] op_b   [16];
  logic       op_sel [16];
  res_t       sb     [$];

  task automatic run_stream(input int n_ops, input bit use_stall, input int bubble_at,
                            input int exp_gaps, input string tag);
    int   op_idx        = 0;
    int   received      = 0;
    int   cycles        = 0;
    int   gaps          = 0;
    int   stall_left    = 0;
    int   stall_n       = 0;
    bit   stall_started = 0;
    bit   bubble_done   = 0;
    bit   seen_first    = 0;
    res_t hold;
    res_t front;
    sb.delete();
    do begin
      @(posedge clk);
      #1;
      if (use_stall && !stall_started && out_valid) begin
        stall_started = 1;
        stall_left    = 3;
      end
      out_ready = (stall_left == 0);
      if (op_idx < n_ops && !(op_idx == bubble_at && !bubble_done)) begin
        in_valid = 1'b1;
        e_a      = op_a[op_idx];
        e_b      = op_b[op_idx];
        sel      = op_sel[op_idx];
      end else begin
        in_valid = 1'b0;
        if (op_idx == bubble_at && op_idx < n_ops) bubble_done = 1;
      end
      #1;
      if (stall_left > 0) begin
        check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
        check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
        if (stall_n == 0) begin
          hold.e = e; hold.ovf = ovf; hold.unf = unf; hold.spec = spec;
        end else begin
          check({tag, " stall e hold"}, 32'(e), 32'(hold.e));
          check({tag, " stall flags hold"}, 32'({ovf, unf, spec}),
                32'({hold.ovf, hold.unf, hold.spec}));
        end
        stall_n++;
        stall_left--;
      end
      if (out_valid) seen_first = 1;
      else if (seen_first) gaps++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check({tag, " unexpected output"}, 32'd1, 32'd0);
        end else begin
          front = sb.pop_front();
          check({tag, " e"},    32'(e),    32'(front.e));
          check({tag, " ovf"},  32'(ovf),  32'(front.ovf));
          check({tag, " unf"},  32'(unf),  32'(front.unf));
          check({tag, " spec"}, 32'(spec), 32'(front.spec));
        end
        received++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(op_a[op_idx], op_b[op_idx], op_sel[op_idx]));
        op_idx++;
      end
      cycles++;
    end while (received < n_ops && cycles < 100);
    check({tag, " results received"}, 32'(received), 32'(n_ops));
    check({tag, " bubble gaps"}, 32'(gaps), 32'(exp_gaps));
    if (use_stall) check({tag, " stall cycles"}, 32'(stall_n), 32'd3);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check({tag, " no duplicate"}, 32'(out_valid), 32'd0);
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{8'd130, 8'd127, 1'b0, 10'd130,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'd127, 8'd130, 1'b1, 10'd124,  1'b0, 1'b0, 1'b0};
    vecs[2]  = '{8'd200, 8'd200, 1'b0, 10'd273,  1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'd1,   8'd254, 1'b1, 10'h382,  1'b0, 1'b1, 1'b0};
    vecs[4]  = '{8'd64,  8'd64,  1'b0, 10'd1,    1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'd0,   8'd100, 1'b0, 10'h3E5,  1'b0, 1'b1, 1'b1};
    vecs[6]  = '{8'd255, 8'd1,   1'b1, 10'd381,  1'b1, 1'b0, 1'b1};
    vecs[7]  = '{8'd254, 8'd127, 1'b0, 10'd254,  1'b0, 1'b0, 1'b0};  // top legal
    vecs[8]  = '{8'd254, 8'd128, 1'b0, 10'd255,  1'b1, 1'b0, 1'b0};  // just over
    vecs[9]  = '{8'd1,   8'd126, 1'b0, 10'd0,    1'b0, 1'b1, 1'b0};  // just under
    vecs[10] = '{8'd127, 8'd127, 1'b1, 10'd127,  1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'd128, 8'd254, 1'b1, 10'd1,    1'b0, 1'b0, 1'b0};  // div bottom
    vecs[12] = '{8'd255, 8'd255, 1'b0, 10'd383,  1'b1, 1'b0, 1'b1};
    vecs[13] = '{8'd10,  8'd0,   1'b1, 10'd137,  1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    e_a = 8'd200; e_b = 8'd200; sel = 1'b0;

    // Reset held for two cycles while inputs are valid.
    tick(); tick();
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset e", 32'(e), 32'd0);
    check("reset flags", 32'({ovf, unf, spec}), 32'd0);

    // One op is accepted and then reset again before it reaches the output.
    rst_n = 1'b1; in_valid = 1'b1;
    tick();
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    check("midreset out_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post reset in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no stale output", 32'(out_valid), 32'd0);
    end

    // Directed table: one isolated op each, checking the 2-cycle latency.
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      e_a = vecs[i].a; e_b = vecs[i].b; sel = vecs[i].sel;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check($sformatf("vec%0d latency1", i), 32'(out_valid), 32'd0);
      tick();
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d e", i), 32'(e),
            32'(shown_e(vecs[i].e, vecs[i].ovf, vecs[i].unf)));
      check($sformatf("vec%0d ovf", i),  32'(ovf),  32'(vecs[i].ovf));
      check($sformatf("vec%0d unf", i),  32'(unf),  32'(vecs[i].unf));
      check($sformatf("vec%0d spec", i), 32'(spec), 32'(vecs[i].spec));
    end

    // Backpressure: 4 back-to-back ops, output stalled 3 cycles.
    op_a[0] = 8'd130; op_b[0] = 8'd127; op_sel[0] = 1'b0;
    op_a[1] = 8'd200; op_b[1] = 8'd200; op_sel[1] = 1'b0;
    op_a[2] = 8'd1;   op_b[2] = 8'd254; op_sel[2] = 1'b1;
    op_a[3] = 8'd0;   op_b[3] = 8'd100; op_sel[3] = 1'b0;
    run_stream(4, 1'b1, -1, 0, "bp");

    // Full throughput: 16 random ops with a single bubble before op 8.
    for (int i = 0; i < 16; i++) begin
      op_a[i]   = 8'($urandom_range(0, 255));
      op_b[i]   = 8'($urandom_range(0, 255));
      op_sel[i] = 1'($urandom_range(0, 1));
    end
    run_stream(16, 1'b0, 8, 1, "tput");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exponent_unit_pipe.md
Name: exponent_unit_pipe

Overview:
Parametrised, handshaked successor to the fixed 8-bit exponent path of the FP multiplier/divider. It computes the biased result exponent for multiply (ea + eb − bias) or divide (ea − eb + bias) for any exponent width. It uses a 2-stage valid/ready pipeline and produces overflow, underflow and special-operand flags. It sits between operand unpacking and the normaliser/rounder in mul_div.

Parameters:
EXP_W, 8, exponent field width in bits (≥3); BIAS = 2^(EXP_W−1) − 1 derived internally
OUT_W, EXP_W+2, result width, signed two's complement; must be ≥ EXP_W+2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operand set valid
in_ready  out  1  unit can accept operands this cycle
e_a  in  EXP_W  biased exponent of A
e_b  in  EXP_W  biased exponent of B
sel  in  1  operation: 0 = multiply, 1 = divide
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
e  out  OUT_W  result exponent, signed
ovf  out  1  result > 2^EXP_W − 2
unf  out  1  result < 1
spec  out  1  e_a or e_b all-zeros or all-ones (zero/denormal/inf/NaN)

Behaviour:
- Reset (rst_n low at a clk edge): both stage valids cleared. out_valid=0, e=0, ovf=0, unf=0, spec=0. in_ready=1 from the first cycle after reset.
- Reset mid-operation: in-flight data is discarded with no output. The first result after release comes only from a new transfer.
- Transfer rules: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Advance condition: adv = !out_valid || out_ready. in_ready = adv. Both stages advance together only when adv=1; otherwise all stage registers hold.
- Stage 1 (on adv): registers e_a, e_b, sel and s1_valid = in_valid. It also registers spec_pre = (e_a==0 | e_a==all-ones | e_b==0 | e_b==all-ones).
- Stage 2 (on adv): computes and registers all outputs, with out_valid = s1_valid.
  - Operands zero-extended to OUT_W.
  - Multiply: e = a + b − BIAS. Divide: e = a − b + BIAS. All arithmetic is OUT_W wide, signed, no wrap for legal OUT_W.
  - ovf = (e > 2^EXP_W − 2) signed compare; unf = (e < 1) signed compare; spec = spec_pre.
  - ovf and unf are mutually exclusive.
- Latency: 2 cycles from input transfer to out_valid, with no stalls. Throughput is 1 result per cycle while out_ready=1.
- Backpressure: while out_valid && !out_ready, e/ovf/unf/spec/out_valid hold stable and in_ready=0.
- A bubble (in_valid=0 at transfer) propagates as out_valid=0. The e/flag values under out_valid=0 are don't-care.
- Simultaneous output transfer and input transfer in the same cycle is legal, with no bubble inserted.
- Outputs of stage 2 are registered; only in_ready is combinational (from out_valid, out_ready).

Optional Feature:
EXP_SAT_EN
- Defined: stage 2 clamps the exponent. If ovf, e = 2^EXP_W − 1 (all-ones, inf encoding). If unf, e = 0. The flags are still reported, and e always fits in EXP_W unsigned bits with upper bits zero.
- Undefined: e carries the raw signed result. Flags behave identically.
- Latency is unchanged in both cases.

Test Plan:
- Reset: rst_n=0 for 2 cycles while in_valid=1 → out_valid=0, e=0, all flags 0; in_ready=1 after release; no output appears for pre-reset inputs.
- Multiply normal (EXP_W=8): e_a=130, e_b=127, sel=0 → 2 cycles later out_valid=1, e=130, ovf=unf=spec=0. Divide e_a=127, e_b=130, sel=1 → e=124.
- Overflow/underflow:
  - mul e_a=200, e_b=200 → e=273, ovf=1 (EXP_SAT_EN: e=255).
  - div e_a=1, e_b=254 → e=−126 (10'h382), unf=1 (EXP_SAT_EN: e=0).
  - mul e_a=64, e_b=64 → e=1, unf=0.
- Special: e_a=0, e_b=100, mul → spec=1, e=−27 (10'h3E5), unf=1. e_a=255, e_b=1, div → spec=1, e=381, ovf=1.
- Backpressure: stream 4 back-to-back ops with out_ready=0 for 3 cycles after the first out_valid → first result held stable, in_ready=0 during the stall. After release, all 4 results appear in order with no loss or duplication.
- Full-throughput: 16 random ops with in_valid=out_ready=1 every cycle → 16 consecutive out_valid cycles matching a reference model, including a mid-stream bubble cycle producing exactly one out_valid=0 gap.
